// File: rtl/otter_dbg_pkg.sv
// Shared definitions for the OTTER debug readout blocks.
//   XLEN_DEF / ADDR_W_DEF : default register width and register index width
//   state_t               : dump engine states (IDLE, READ, SEND)
//   dump_word_t           : one streamed word at default widths (data, idx, last)
package otter_dbg_pkg;

  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN_DEF-1:0]   data;
    logic [ADDR_W_DEF-1:0] idx;
    logic                  last;
  } dump_word_t;

endpackage

// File: rtl/reg_dump_reader.sv
// Debug readout engine for the OTTER register file.
// Walks first_reg..last_reg through the register file's spare read port and
// streams each value over a valid/ready interface, holding the core while
// active so the snapshot is consistent.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   start, first_reg,        dump request and inclusive index range,
//   last_reg                 sampled only in IDLE
//   abort                    cancel an in-progress dump (no done pulse)
//   rd_adr / rd_data         register-file read port (combinational read)
//   cpu_hold, busy           high whenever not IDLE
//   out_valid/out_ready      stream handshake
//   out_data/out_idx/out_last word, its index, last-of-range flag
//   done                     one-cycle pulse on completion or rejected range
//   range_err                one-cycle pulse with done when first_reg > last_reg
module reg_dump_reader
  import otter_dbg_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_adr,
  input  logic [XLEN-1:0]   rd_data,
  output logic              cpu_hold,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              range_err
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              lastf_q, lastf_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              rerr_q, rerr_d;
  logic              load;

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    last_d   = last_q;
    data_d   = data_q;
    idx_d    = idx_q;
    lastf_d  = lastf_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    rerr_d   = 1'b0;
    load     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (first_reg <= last_reg) begin
            rd_ptr_d = first_reg;
            last_d   = last_reg;
            state_d  = READ;
          end else begin
            done_d = 1'b1;
            rerr_d = 1'b1;
          end
        end
      end
      READ: begin
        load    = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (out_ready) begin
          if (lastf_q) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            // Refill the holding register on the accepting edge so a
            // continuously ready sink sees one word per cycle.
            load = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      data_d   = rd_data;
      idx_d    = rd_ptr_q;
      lastf_d  = (rd_ptr_q == last_q);
      valid_d  = 1'b1;
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end

    // Abort overrides any coincident handshake or completion.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      valid_d = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      last_q   <= '0;
      data_q   <= '0;
      idx_q    <= '0;
      lastf_q  <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      last_q   <= last_d;
      data_q   <= data_d;
      idx_q    <= idx_d;
      lastf_q  <= lastf_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      rerr_q   <= rerr_d;
    end
  end

  assign rd_adr    = rd_ptr_q;
  assign cpu_hold  = (state_q != IDLE);
  assign busy      = cpu_hold;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_idx   = idx_q;
  assign out_last  = lastf_q;
  assign done      = done_q;
  assign range_err = rerr_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader with a behavioural 32x32 register file
// (x0 reads 0, writes gated by cpu_hold) as the read target.
module tb_reg_dump_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  first_reg, last_reg;
  logic        abort;
  logic [4:0]  rd_adr;
  logic [31:0] rd_data;
  logic        cpu_hold, out_valid, out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_idx;
  logic        out_last, busy, done, range_err;

  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] rf [32];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg_dump_reader #(.XLEN(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .first_reg(first_reg),
    .last_reg(last_reg), .abort(abort), .rd_adr(rd_adr), .rd_data(rd_data),
    .cpu_hold(cpu_hold), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .busy(busy), .done(done), .range_err(range_err)
  );

  assign rd_data = (rd_adr == 5'd0) ? 32'd0 : rf[rd_adr];

  always @(posedge clk)
    if (wr_en && !cpu_hold && (wr_addr != 5'd0))
      rf[wr_addr] <= wr_data;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [4:0] f, input logic [4:0] l);
    first_reg = f;
    last_reg  = l;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  function automatic logic [31:0] init_val(input int unsigned i);
    return (i == 0) ? 32'd0 : 32'h1000_0000 + i;
  endfunction

  initial begin
    logic [5:0]  rdy_seq;
    int unsigned exp_idx;

    rst = 1'b1; start = 1'b0; first_reg = '0; last_reg = '0; abort = 1'b0;
    out_ready = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;

    // Reset values
    tick(); tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_hold",  32'(cpu_hold),  32'd0);
    check("rst_done",  32'(done),      32'd0);
    check("rst_rerr",  32'(range_err), 32'd0);
    check("rst_adr",   32'(rd_adr),    32'd0);
    check("rst_data",  out_data,       32'd0);
    check("rst_idx",   32'(out_idx),   32'd0);
    check("rst_last",  32'(out_last),  32'd0);
    rst = 1'b0;

    // Preload xi = 0x1000_0000 + i through the write port
    for (int i = 1; i < 32; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'h1000_0000 + 32'(i);
      tick();
    end
    wr_en = 1'b0;

    // Full dump at full rate
    out_ready = 1'b1;
    pulse_start(5'd0, 5'd31);
    check("full_busy_early",  32'(busy),      32'd1);
    check("full_valid_early", 32'(out_valid), 32'd0);
    tick();
    for (int i = 0; i < 32; i++) begin
      check("full_valid", 32'(out_valid), 32'd1);
      check("full_idx",   32'(out_idx),   32'(i));
      check("full_data",  out_data,       init_val(i));
      check("full_last",  32'(out_last),  32'(i == 31));
      check("full_hold",  32'(cpu_hold),  32'd1);
      tick();
    end
    check("full_done",      32'(done),      32'd1);
    check("full_valid_end", 32'(out_valid), 32'd0);
    check("full_busy_end",  32'(busy),      32'd0);
    tick();
    check("full_done_pulse", 32'(done), 32'd0);

    // Backpressure: ready 0,0,1,0,1,1 over range 5..7
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
    tick();
    wr_en = 1'b0;
    out_ready = 1'b0;
    pulse_start(5'd5, 5'd7);
    tick();
    rdy_seq = 6'b110100;
    exp_idx = 5;
    for (int k = 0; k < 6; k++) begin
      out_ready = rdy_seq[k];
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_idx",   32'(out_idx),   32'(exp_idx));
      check("bp_data",  out_data, (exp_idx == 5) ? 32'hDEAD_BEEF : init_val(exp_idx));
      check("bp_last",  32'(out_last),  32'(exp_idx == 7));
      if (out_ready) exp_idx++;
      tick();
    end
    check("bp_done",  32'(done),      32'd1);
    check("bp_valid_end", 32'(out_valid), 32'd0);

    // Single register 12..12
    out_ready = 1'b0;
    pulse_start(5'd12, 5'd12);
    tick();
    check("one_valid", 32'(out_valid), 32'd1);
    check("one_idx",   32'(out_idx),   32'd12);
    check("one_last",  32'(out_last),  32'd1);
    check("one_data",  out_data,       32'h1000_000C);
    out_ready = 1'b1;
    tick();
    check("one_done",  32'(done),      32'd1);
    check("one_valid_end", 32'(out_valid), 32'd0);

    // Bad range 9..3
    pulse_start(5'd9, 5'd3);
    check("bad_done",  32'(done),      32'd1);
    check("bad_rerr",  32'(range_err), 32'd1);
    check("bad_busy",  32'(busy),      32'd0);
    check("bad_valid", 32'(out_valid), 32'd0);
    tick();
    check("bad_done_pulse", 32'(done),      32'd0);
    check("bad_rerr_pulse", 32'(range_err), 32'd0);
    check("bad_valid2",     32'(out_valid), 32'd0);
    check("bad_busy2",      32'(busy),      32'd0);

    // Abort after the 4th handshake, coinciding with a 5th handshake
    pulse_start(5'd0, 5'd31);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("ab_idx", 32'(out_idx), 32'(i));
      tick();
    end
    check("ab_idx4", 32'(out_idx), 32'd4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_valid", 32'(out_valid), 32'd0);
    check("ab_busy",  32'(busy),      32'd0);
    check("ab_done",  32'(done),      32'd0);
    tick();
    check("ab_done2",  32'(done),      32'd0);
    check("ab_valid2", 32'(out_valid), 32'd0);

    // Start during an active dump is ignored
    pulse_start(5'd10, 5'd13);
    tick();
    for (int i = 10; i < 14; i++) begin
      if (i == 10) begin
        first_reg = 5'd0; last_reg = 5'd2; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      check("bs_idx",  32'(out_idx),  32'(i));
      check("bs_data", out_data,      init_val(i));
      check("bs_last", 32'(out_last), 32'(i == 13));
      tick();
    end
    start = 1'b0;
    check("bs_done", 32'(done), 32'd1);

    // Write blocking while dumping 8..12
    pulse_start(5'd8, 5'd12);
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'hCAFE_F00D;
    tick();
    for (int i = 8; i < 13; i++) begin
      check("wb_idx",  32'(out_idx), 32'(i));
      check("wb_data", out_data,     init_val(i));
      tick();
    end
    check("wb_done",    32'(done), 32'd1);
    check("wb_busy",    32'(busy), 32'd0);
    check("wb_blocked", rf[10],    32'h1000_000A);
    tick();
    wr_en = 1'b0;
    check("wb_landed",  rf[10],    32'hCAFE_F00D);

    // Reset mid-dump after 3 words
    pulse_start(5'd0, 5'd31);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("rm_idx", 32'(out_idx), 32'(i));
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rm_valid", 32'(out_valid), 32'd0);
    check("rm_busy",  32'(busy),      32'd0);
    check("rm_done",  32'(done),      32'd0);
    check("rm_adr",   32'(rd_adr),    32'd0);
    check("rm_idx0",  32'(out_idx),   32'd0);
    tick();
    check("rm_done2", 32'(done),      32'd0);
    check("rm_valid2", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
